s_mem_task_sequencer: RTL and testbench

- Sequences the three RC4 stages in fixed order: S-array init (task1), key schedule (task2a), then decrypt (task2b).
- Uses a start/finish pulse handshake with each stage FSM.
- Owns the single port of the shared s_memory and grants it to exactly one stage at a time. Non-granted stages cannot corrupt memory, unlike an OR-merge of stage outputs.
- Adds a per-stage watchdog, and reports busy/done/error to the top level.

---
 rtl/s_mem_task_sequencer.sv | 162 ++++++++++++++++
 tb/tb_s_mem_task_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mem_task_sequencer.sv
// RC4 stage sequencer: runs task1 -> task2a -> task2b with start/finish pulses,
// grants the single s_memory port to the active stage only, and guards each
// stage with a watchdog that latches a sticky timeout error.
module s_mem_task_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TCNT_W         = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    output logic [2:0] start_task,
    input  logic [2:0] finish_task,
    input  logic [7:0] t1_address,
    input  logic [7:0] t2a_address,
    input  logic [7:0] t2b_address,
    input  logic [7:0] t1_data,
    input  logic [7:0] t2a_data,
    input  logic [7:0] t2b_data,
    input  logic       t1_wren,
    input  logic       t2a_wren,
    input  logic       t2b_wren,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data,
    output logic       mem_wren,
    output logic [1:0] active_task,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [1:0] err_task
);

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START_T1  = 4'd1,
        WAIT_T1   = 4'd2,
        START_T2A = 4'd3,
        WAIT_T2A  = 4'd4,
        START_T2B = 4'd5,
        WAIT_T2B  = 4'd6,
        DONE      = 4'd7,
        ERROR     = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [2:0]        start_task_q, start_task_d;
    logic [1:0]        active_task_q, active_task_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_err_q, timeout_err_d;
    logic [1:0]        err_task_q, err_task_d;
    logic              expire_c;
    logic              in_start_c;
    logic              running_c;

    // Watchdog expiry: the current cycle is the last one the stage is allowed.
    assign expire_c = (TIMEOUT_CYCLES != 0) && (tcnt_q == TCNT_LAST);

    // State and registered outputs; async reset drops pulses and grant at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tcnt_q        <= '0;
            start_task_q  <= 3'b000;
            active_task_q <= 2'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            err_task_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            start_task_q  <= start_task_d;
            active_task_q <= active_task_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            err_task_q    <= err_task_d;
        end
    end

    // Next state: finish only counts in WAIT for the active stage; finish beats expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: if (go) state_d = START_T1;
            START_T1:  state_d = expire_c ? ERROR : WAIT_T1;
            WAIT_T1: begin
                if (finish_task[0])  state_d = START_T2A;
                else if (expire_c)   state_d = ERROR;
            end
            START_T2A: state_d = expire_c ? ERROR : WAIT_T2A;
            WAIT_T2A: begin
                if (finish_task[1])  state_d = START_T2B;
                else if (expire_c)   state_d = ERROR;
            end
            START_T2B: state_d = expire_c ? ERROR : WAIT_T2B;
            WAIT_T2B: begin
                if (finish_task[2])  state_d = DONE;
                else if (expire_c)   state_d = ERROR;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Output and watchdog next values, decoded from the upcoming state.
    always_comb begin
        start_task_d  = 3'b000;
        active_task_d = 2'd0;
        busy_d        = 1'b0;
        done_d        = (state_d == DONE);
        timeout_err_d = (state_d == ERROR);
        err_task_d    = 2'd0;
        in_start_c    = (state_d == START_T1) || (state_d == START_T2A) ||
                        (state_d == START_T2B);
        running_c     = (state_q == START_T1) || (state_q == WAIT_T1)  ||
                        (state_q == START_T2A) || (state_q == WAIT_T2A) ||
                        (state_q == START_T2B) || (state_q == WAIT_T2B);
        tcnt_d        = '0;

        unique case (state_d)
            START_T1:  begin start_task_d = 3'b001; active_task_d = 2'd1; busy_d = 1'b1; end
            WAIT_T1:   begin active_task_d = 2'd1; busy_d = 1'b1; end
            START_T2A: begin start_task_d = 3'b010; active_task_d = 2'd2; busy_d = 1'b1; end
            WAIT_T2A:  begin active_task_d = 2'd2; busy_d = 1'b1; end
            START_T2B: begin start_task_d = 3'b100; active_task_d = 2'd3; busy_d = 1'b1; end
            WAIT_T2B:  begin active_task_d = 2'd3; busy_d = 1'b1; end
            default:   ;
        endcase

        if (state_d == ERROR)
            err_task_d = (state_q == ERROR) ? err_task_q : active_task_q;

        if (in_start_c)
            tcnt_d = '0;
        else if (running_c)
            tcnt_d = tcnt_q + TCNT_W'(1);
    end

    // Memory port mux from the registered grant; ungranted stages never reach s_memory.
    always_comb begin
        mem_address = 8'h00;
        mem_data    = 8'h00;
        mem_wren    = 1'b0;
        unique case (active_task_q)
            2'd1:    begin mem_address = t1_address;  mem_data = t1_data;  mem_wren = t1_wren;  end
            2'd2:    begin mem_address = t2a_address; mem_data = t2a_data; mem_wren = t2a_wren; end
            2'd3:    begin mem_address = t2b_address; mem_data = t2b_data; mem_wren = t2b_wren; end
            default: ;
        endcase
    end

    assign start_task  = start_task_q;
    assign active_task = active_task_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign err_task    = err_task_q;

endmodule

// File: tb/tb_s_mem_task_sequencer.sv
// Directed bench for s_mem_task_sequencer with a 16-cycle watchdog.
module tb_s_mem_task_sequencer;

    logic       clock;
    logic       reset;
    logic       go;
    logic [2:0] start_task;
    logic [2:0] finish_task;
    logic [7:0] t1_address, t2a_address, t2b_address;
    logic [7:0] t1_data, t2a_data, t2b_data;
    logic       t1_wren, t2a_wren, t2b_wren;
    logic [7:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_wren;
    logic [1:0] active_task;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [1:0] err_task;

    int n_checks = 0;
    int n_fail   = 0;

    s_mem_task_sequencer #(
        .TIMEOUT_CYCLES(16),
        .TCNT_W        (13)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
        .start_task (start_task),
        .finish_task(finish_task),
        .t1_address (t1_address),
        .t2a_address(t2a_address),
        .t2b_address(t2b_address),
        .t1_data    (t1_data),
        .t2a_data   (t2a_data),
        .t2b_data   (t2b_data),
        .t1_wren    (t1_wren),
        .t2a_wren   (t2a_wren),
        .t2b_wren   (t2b_wren),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .active_task(active_task),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .err_task   (err_task)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    // From a START cycle: finish one cycle later, land in the next START/DONE.
    task automatic quick_finish(input int x);
        step();
        finish_task = 3'(1 << x);
        step();
        finish_task = 3'b000;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_checks++;
        if ({start_task, active_task, busy, done, timeout_err, err_task} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b act=%0d busy=%b done=%b terr=%b etask=%0d, want all 0",
                     start_task, active_task, busy, done, timeout_err, err_task);
        end
        n_checks++;
        if ({mem_address, mem_data, mem_wren} !== 17'b0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr=%h data=%h wren=%b, want 0", mem_address, mem_data, mem_wren);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if ({start_task, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got start=%b busy=%b, want 000/0", start_task, busy);
        end
    endtask

    task automatic test_nominal();
        pulse_go();
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if ({start_task, active_task, busy} !== {3'(1 << s), 2'(s + 1), 1'b1}) begin
                n_fail++;
                $display("FAIL nom_start%0d: got start=%b act=%0d busy=%b, want start=%b act=%0d busy=1",
                         s, start_task, active_task, busy, 3'(1 << s), s + 1);
            end
            for (int i = 1; i <= 5; i++) begin
                step();
                n_checks++;
                if ({start_task, active_task, busy, done} !== {3'b000, 2'(s + 1), 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL nom_wait%0d_c%0d: got start=%b act=%0d busy=%b done=%b, want 000/%0d/1/0",
                             s, i, start_task, active_task, busy, done, s + 1);
                end
            end
            finish_task = 3'(1 << s);
            step();
            finish_task = 3'b000;
        end
        n_checks++;
        if ({start_task, active_task, busy, done} !== {3'b000, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL nom_done: got start=%b act=%0d busy=%b done=%b, want 000/0/0/1",
                     start_task, active_task, busy, done);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_done_sticky: got done=%b busy=%b, want 1/0", done, busy);
        end
    endtask

    task automatic test_mux_isolation();
        hold_reset();
        t1_address = 8'h11; t1_data = 8'hA1; t1_wren = 1'b1;
        t2a_address = 8'h22; t2a_data = 8'h5A; t2a_wren = 1'b1;
        t2b_address = 8'h33; t2b_data = 8'hC3; t2b_wren = 1'b1;
        #1;
        n_checks++;
        if ({mem_address, mem_data, mem_wren} !== 17'b0) begin
            n_fail++;
            $display("FAIL mux_idle: got addr=%h data=%h wren=%b, want 00/00/0", mem_address, mem_data, mem_wren);
        end
        pulse_go();
        n_checks++;
        if ({mem_address, mem_data, mem_wren} !== {8'h11, 8'hA1, 1'b1}) begin
            n_fail++;
            $display("FAIL mux_t1: got addr=%h data=%h wren=%b, want 11/a1/1", mem_address, mem_data, mem_wren);
        end
        quick_finish(0);
        step();
        n_checks++;
        if ({mem_address, mem_data, mem_wren} !== {8'h22, 8'h5A, 1'b1}) begin
            n_fail++;
            $display("FAIL mux_t2a: got addr=%h data=%h wren=%b, want 22/5a/1", mem_address, mem_data, mem_wren);
        end
        t2a_wren = 1'b0;
        #1;
        n_checks++;
        if (mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL mux_t2a_wren_only: got wren=%b, want 0", mem_wren);
        end
        finish_task = 3'b010;
        step();
        finish_task = 3'b000;
        t1_wren = 1'b0; t2a_wren = 1'b1; t2b_wren = 1'b0;
        #1;
        n_checks++;
        if ({mem_address, mem_data, mem_wren} !== {8'h33, 8'hC3, 1'b0}) begin
            n_fail++;
            $display("FAIL mux_t2b: got addr=%h data=%h wren=%b, want 33/c3/0", mem_address, mem_data, mem_wren);
        end
        quick_finish(2);
        n_checks++;
        if ({done, mem_address, mem_wren} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL mux_done: got done=%b addr=%h wren=%b, want 1/00/0", done, mem_address, mem_wren);
        end
        t1_wren = 1'b0; t2a_wren = 1'b0; t2b_wren = 1'b0;
    endtask

    task automatic test_timeout();
        int bad_starts;
        bad_starts = 0;
        pulse_go();
        quick_finish(0);
        n_checks++;
        if (start_task !== 3'b010) begin
            n_fail++;
            $display("FAIL to_t2a_start: got start=%b, want 010", start_task);
        end
        for (int i = 1; i <= 15; i++) begin
            step();
            n_checks++;
            if ({timeout_err, active_task, busy} !== {1'b0, 2'd2, 1'b1}) begin
                n_fail++;
                $display("FAIL to_pre_c%0d: got terr=%b act=%0d busy=%b, want 0/2/1",
                         i, timeout_err, active_task, busy);
            end
        end
        step();
        n_checks++;
        if ({timeout_err, err_task, busy, active_task, start_task} !== {1'b1, 2'd2, 1'b0, 2'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL to_expire: got terr=%b etask=%0d busy=%b act=%0d start=%b, want 1/2/0/0/000",
                     timeout_err, err_task, busy, active_task, start_task);
        end
        finish_task = 3'b110;
        for (int i = 0; i < 20; i++) begin
            step();
            if (start_task !== 3'b000 || timeout_err !== 1'b1) bad_starts++;
        end
        finish_task = 3'b000;
        n_checks++;
        if (bad_starts !== 0) begin
            n_fail++;
            $display("FAIL to_hold: %0d cycles with a start pulse or cleared error, want 0", bad_starts);
        end
        pulse_go();
        n_checks++;
        if ({timeout_err, err_task, start_task, busy} !== {1'b0, 2'd0, 3'b001, 1'b1}) begin
            n_fail++;
            $display("FAIL to_restart: got terr=%b etask=%0d start=%b busy=%b, want 0/0/001/1",
                     timeout_err, err_task, start_task, busy);
        end
        quick_finish(0);
        quick_finish(1);
        quick_finish(2);
        n_checks++;
        if ({done, timeout_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL to_restart_done: got done=%b terr=%b, want 1/0", done, timeout_err);
        end
    endtask

    task automatic test_coincident();
        pulse_go();
        for (int i = 1; i <= 15; i++) step();
        n_checks++;
        if ({timeout_err, active_task} !== {1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL co_pre: got terr=%b act=%0d, want 0/1", timeout_err, active_task);
        end
        finish_task = 3'b001;
        step();
        finish_task = 3'b000;
        n_checks++;
        if ({start_task, timeout_err, active_task, busy} !== {3'b010, 1'b0, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL co_finish_wins: got start=%b terr=%b act=%0d busy=%b, want 010/0/2/1",
                     start_task, timeout_err, active_task, busy);
        end
        quick_finish(1);
        quick_finish(2);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL co_done: got done=%b, want 1", done);
        end
    endtask

    task automatic test_spurious();
        pulse_go();
        finish_task = 3'b001;
        step();
        finish_task = 3'b000;
        n_checks++;
        if ({start_task, active_task} !== {3'b000, 2'd1}) begin
            n_fail++;
            $display("FAIL sp_early_finish: got start=%b act=%0d, want 000/1", start_task, active_task);
        end
        pulse_go();
        n_checks++;
        if ({start_task, active_task, busy} !== {3'b000, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL sp_go_busy: got start=%b act=%0d busy=%b, want 000/1/1", start_task, active_task, busy);
        end
        finish_task = 3'b110;
        step();
        finish_task = 3'b000;
        n_checks++;
        if ({start_task, active_task} !== {3'b000, 2'd1}) begin
            n_fail++;
            $display("FAIL sp_other_finish: got start=%b act=%0d, want 000/1", start_task, active_task);
        end
        finish_task = 3'b001;
        step();
        finish_task = 3'b000;
        n_checks++;
        if (start_task !== 3'b010) begin
            n_fail++;
            $display("FAIL sp_real_finish: got start=%b, want 010", start_task);
        end
        quick_finish(1);
        quick_finish(2);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL sp_done: got done=%b, want 1", done);
        end
    endtask

    task automatic test_reset_mid_op();
        pulse_go();
        quick_finish(0);
        quick_finish(1);
        step();
        t1_wren = 1'b1; t2a_wren = 1'b1; t2b_wren = 1'b1;
        #1;
        n_checks++;
        if ({active_task, mem_address, mem_wren} !== {2'd3, 8'h33, 1'b1}) begin
            n_fail++;
            $display("FAIL rm_pre: got act=%0d addr=%h wren=%b, want 3/33/1", active_task, mem_address, mem_wren);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({start_task, active_task, busy, done, timeout_err, err_task,
             mem_address, mem_data, mem_wren} !== 28'b0) begin
            n_fail++;
            $display("FAIL rm_async: got start=%b act=%0d busy=%b done=%b terr=%b etask=%0d addr=%h data=%h wren=%b, want all 0",
                     start_task, active_task, busy, done, timeout_err, err_task, mem_address, mem_data, mem_wren);
        end
        t1_wren = 1'b0; t2a_wren = 1'b0; t2b_wren = 1'b0;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if ({start_task, busy, active_task} !== 6'b0) begin
            n_fail++;
            $display("FAIL rm_idle: got start=%b busy=%b act=%0d, want 000/0/0", start_task, busy, active_task);
        end
        pulse_go();
        n_checks++;
        if (start_task !== 3'b001) begin
            n_fail++;
            $display("FAIL rm_rerun_start: got start=%b, want 001", start_task);
        end
        quick_finish(0);
        quick_finish(1);
        quick_finish(2);
        n_checks++;
        if ({done, busy, timeout_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL rm_rerun_done: got done=%b busy=%b terr=%b, want 1/0/0", done, busy, timeout_err);
        end
    endtask

    initial begin
        reset       = 1'b1;
        go          = 1'b0;
        finish_task = 3'b000;
        t1_address  = 8'h00; t2a_address = 8'h00; t2b_address = 8'h00;
        t1_data     = 8'h00; t2a_data    = 8'h00; t2b_data    = 8'h00;
        t1_wren     = 1'b0;  t2a_wren    = 1'b0;  t2b_wren    = 1'b0;

        test_reset();
        test_nominal();
        test_mux_isolation();
        test_timeout();
        test_coincident();
        test_spurious();
        test_reset_mid_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
